// File: rtl/seven_seg_capture.sv
// rtl/seven_seg_capture.sv - observes multiplexed 7-seg anode/segment lines and decodes the displayed hex digits
// Optional per-digit valid timeout enabled with `define SEVEN_SEG_CAPTURE_TIMEOUT_EN.
module seven_seg_capture #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  an,
  input  logic [6:0]  seg,
  output logic [15:0] digits,
  output logic [3:0]  digit_valid,
  output logic        frame_done,
  output logic        bad_pattern
);

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, HOLD} state_t;

  localparam logic [7:0] STABLE_W = 8'(STABLE_CYCLES);

  if (STABLE_CYCLES < 1 || STABLE_CYCLES > 255 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("seven_seg_capture: parameter out of range");
  end

  state_t      state;
  state_t      state_next;
  logic [3:0]  an_q;
  logic [6:0]  seg_q;
  logic [3:0]  lat_an;
  logic [6:0]  lat_seg;
  logic [7:0]  count;
  logic [7:0]  count_next;
  logic        latch;
  logic        one_low;
  logic        pair_changed;
  logic [3:0]  seen;
  logic [3:0]  seen_set;
  logic [1:0]  lat_idx;
  logic [6:0]  pat;
  logic [3:0]  hex_val;
  logic        hex_ok;
  logic        blank;
  logic        capture;

  assign one_low      = (an_q == 4'b1110) || (an_q == 4'b1101) ||
                        (an_q == 4'b1011) || (an_q == 4'b0111);
  assign pair_changed = (an_q != lat_an) || (seg_q != lat_seg);

  // State register plus the latched anode/pattern pair being qualified.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      count   <= 8'd0;
      lat_an  <= 4'hF;
      lat_seg <= 7'h7F;
    end else begin
      state <= state_next;
      count <= count_next;
      if (latch) begin
        lat_an  <= an_q;
        lat_seg <= seg_q;
      end
    end
  end

  // Any change re-arms qualification; with STABLE_CYCLES=1 the first sample already qualifies.
  always_comb begin
    state_next = state;
    count_next = count;
    latch      = 1'b0;
    case (state)
      IDLE: begin
        if (one_low) latch = 1'b1;
      end
      SETTLE: begin
        if (pair_changed) begin
          if (one_low) latch = 1'b1;
          else         state_next = IDLE;
        end else begin
          count_next = (count == 8'hFF) ? count : count + 8'd1;
          if (count_next == STABLE_W) state_next = CAPTURE;
        end
      end
      CAPTURE: state_next = HOLD;
      HOLD: begin
        if (pair_changed) begin
          if (one_low) latch = 1'b1;
          else         state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (latch) begin
      count_next = 8'd1;
      state_next = (STABLE_W == 8'd1) ? CAPTURE : SETTLE;
    end
  end

  // Output decode: which digit is latched and what its pattern means.
  always_comb begin
    capture = (state == CAPTURE);
    pat     = ~lat_seg;
    blank   = (pat == 7'h00);
    hex_ok  = 1'b1;
    hex_val = 4'h0;
    lat_idx = 2'd0;
    case (lat_an)
      4'b1101: lat_idx = 2'd1;
      4'b1011: lat_idx = 2'd2;
      4'b0111: lat_idx = 2'd3;
      default: lat_idx = 2'd0;
    endcase
    case (pat)
      7'h3F: hex_val = 4'h0;
      7'h06: hex_val = 4'h1;
      7'h5B: hex_val = 4'h2;
      7'h4F: hex_val = 4'h3;
      7'h66: hex_val = 4'h4;
      7'h6D: hex_val = 4'h5;
      7'h7D: hex_val = 4'h6;
      7'h07: hex_val = 4'h7;
      7'h7F: hex_val = 4'h8;
      7'h6F: hex_val = 4'h9;
      7'h77: hex_val = 4'hA;
      7'h7C: hex_val = 4'hB;
      7'h39: hex_val = 4'hC;
      7'h5E: hex_val = 4'hD;
      7'h79: hex_val = 4'hE;
      7'h71: hex_val = 4'hF;
      default: hex_ok = 1'b0;
    endcase
    seen_set = seen | (4'b0001 << lat_idx);
  end

`ifdef SEVEN_SEG_CAPTURE_TIMEOUT_EN
  localparam int AW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [AW-1:0] AGE_MAX = AW'(TIMEOUT_CYCLES);
  logic [AW-1:0] age [4];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (reset || (capture && (lat_idx == 2'(i)))) age[i] <= '0;
      else if (age[i] != AGE_MAX)                   age[i] <= age[i] + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      an_q        <= 4'hF;
      seg_q       <= 7'h7F;
      digits      <= 16'h0000;
      digit_valid <= 4'b0000;
      frame_done  <= 1'b0;
      bad_pattern <= 1'b0;
      seen        <= 4'b0000;
    end else begin
      an_q       <= an;
      seg_q      <= seg;
      frame_done <= 1'b0;
`ifdef SEVEN_SEG_CAPTURE_TIMEOUT_EN
      for (int i = 0; i < 4; i++) begin
        if (age[i] == AGE_MAX) digit_valid[i] <= 1'b0;
      end
`endif
      if (capture) begin
        if (hex_ok) begin
          digits[{lat_idx, 2'b00} +: 4] <= hex_val;
          digit_valid[lat_idx]          <= 1'b1;
        end else if (blank) begin
          digit_valid[lat_idx] <= 1'b0;
        end else begin
          bad_pattern <= 1'b1;
        end
        if (seen_set == 4'b1111) begin
          frame_done <= 1'b1;
          seen       <= 4'b0000;
        end else begin
          seen <= seen_set;
        end
      end
    end
  end

endmodule

// File: doc/seven_seg_capture.md
Name: seven_seg_capture

Overview:
- Receive-side counterpart of the display driver path: watches the multiplexed anode/segment lines going to the 4-digit 7-segment display.
- Waits for each digit's pattern to settle, then decodes the segment pattern back into a 4-bit hex value.
- Holds the value in a per-digit register so a bench or on-chip checker can read back what is actually displayed.
- Sits alongside the display driver; purely an observer, never drives the display.

Parameters:
- STABLE_CYCLES, 4, consecutive cycles the anode+segment pair must be unchanged before capture (legal range 1..255).
- TIMEOUT_CYCLES, 100000, cycles without refresh before a digit's valid bit is aged out (used only with the optional feature).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- an  input  4  anode enables, active-low; an[i]=0 selects digit i.
- seg  input  7  segment lines, active-low; seg[0]=a ... seg[6]=g.
- digits  output  16  captured values; digit i in digits[4i+3:4i].
- digit_valid  output  4  bit i set when digits[i] holds a valid decoded value.
- frame_done  output  1  one-cycle pulse when all 4 digits have been captured since the previous pulse.
- bad_pattern  output  1  sticky; set on capture of a non-blank pattern that matches no hex code.

Behaviour:
- Reset:
  - Synchronous, active-high.
  - digits=16'h0000, digit_valid=4'b0000, frame_done=0, bad_pattern=0.
  - Internal: FSM=IDLE, stability counter=0, seen mask=0.
- Sampling:
  - an and seg registered once on input; all decisions use the registered copy.
  - Adds 1 cycle of latency.
- Decode:
  - Invert seg to active-high gfedcba.
  - Hex map: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
  - 00 (blank) is its own class. Every other code is invalid.
- FSM states:
  - IDLE:
    - Stays here while the registered anode has zero or more than one low bit.
    - On exactly one low bit: latch index and pattern, counter=1, go to SETTLE.
  - SETTLE:
    - Anode or pattern differs from the latched pair: re-latch the new pair, counter=1 if exactly one anode is low, otherwise go to IDLE.
    - Unchanged: counter increments.
    - When counter reaches STABLE_CYCLES, go to CAPTURE.
  - CAPTURE (one cycle):
    - Valid hex: write digits[idx], set digit_valid[idx].
    - Blank: clear digit_valid[idx]; digits[idx] unchanged.
    - Invalid: set bad_pattern; digit_valid[idx] unchanged.
    - In all cases set seen[idx], then go to HOLD.
  - HOLD:
    - Stays while the pair is unchanged; no re-capture of the same steady digit.
    - On any change, behaves as the IDLE/SETTLE entry.
- Latency:
  - STABLE_CYCLES=1: value appears on digits 3 clocks after the pair first appears on the pins (register, SETTLE, CAPTURE).
  - In general: STABLE_CYCLES+2 clocks.
- frame_done:
  - When seen becomes 4'b1111 in CAPTURE, pulse frame_done the following cycle and clear seen.
  - A repeated digit before the frame completes does not pulse.
- Boundaries:
  - Counter saturates; no wrap.
  - A ghosting glitch shorter than STABLE_CYCLES is never captured.
  - reset asserted mid-SETTLE or mid-CAPTURE wins; outputs return to reset values the next edge.
  - bad_pattern clears only on reset.

Optional Feature:
- Macro: SEVEN_SEG_CAPTURE_TIMEOUT_EN.
- Defined:
  - One age counter per digit, cleared on each CAPTURE of that digit.
  - When a counter reaches TIMEOUT_CYCLES, digit_valid[i] clears; digits[i] is held.
  - Counters saturate.
- Undefined:
  - No age counters; digit_valid changes only via CAPTURE or reset.
  - TIMEOUT_CYCLES is ignored.

Test Plan:
- Reset, then an=4'b1110, seg=~7'h4F held 10 cycles (STABLE_CYCLES=4) -> digits[3:0]=3, digit_valid=4'b0001 exactly 6 clocks after the first applied edge; bad_pattern=0.
- Scan digits 0..3 with values 1,A,d,F, 8 cycles each, repeat twice -> digits=16'hFDA1, digit_valid=4'hF, frame_done pulses once per scan (2 pulses total).
- Digit 1 shows 7 steady, then a 2-cycle glitch to seg=~7'h7F, then back to 7 -> digits[7:4] stays 7, no capture of 8.
- an=4'b1100 (two anodes) for 20 cycles -> no capture, FSM in IDLE; an=4'b1111 idem.
- Digit 2 shows seg=~7'h01 (invalid) for 6 cycles -> bad_pattern=1 and remains 1; digit_valid[2] unchanged; blank on digit 2 then clears digit_valid[2].
- With SEVEN_SEG_CAPTURE_TIMEOUT_EN, TIMEOUT_CYCLES=50: capture digit 0=5, then an=4'b1111 -> digit_valid[0] clears after 50 cycles, digits[3:0] stays 5. Without the macro it stays 1.
- Reset asserted during SETTLE -> all outputs zero next edge.
